bcd_seg_scan: RTL
=================

# bcd_seg_scan

Multiplexed seven-segment display driver for the BCD counter chain. Captures a packed vector of BCD digits (one nibble per cascaded BCD counter) on a load strobe. Scans the captured digits round-robin onto a common-anode display at a programmable refresh rate. Provides leading-zero blanking and a dash for illegal codes.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits and anode lines (2..8)
- REFRESH_DIV, 4, clock cycles each digit slot is held (>= 2)
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- bcd_in  input  4*DIGITS  packed BCD digits; nibble i = digit i, digit 0 = least significant
- load  input  1  capture strobe; bcd_in sampled on a rising edge with load=1
- seg  output  7  active-low segments {g,f,e,d,c,b,a}
- an  output  DIGITS  active-low anode enables, one-hot-low or all-high
- frame  output  1  one-cycle pulse on the first cycle of each digit-0 slot

## Operation
- Internal state:
  - shadow: 4*DIGITS-bit capture register.
  - div_cnt: 0..REFRESH_DIV-1.
  - dig_idx: 0..DIGITS-1.
- div_cnt increments every cycle. It wraps to 0 after REFRESH_DIV-1.
- dig_idx advances on the cycle div_cnt==REFRESH_DIV-1. It wraps DIGITS-1 -> 0.
- The load edge sets shadow <= bcd_in. Without load, shadow holds. Load does not disturb div_cnt or dig_idx.
- Decode, active-low {g..a}:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - 10..15 = 0x3F (dash, g only)
- Blanking, when BLANK_LZ=1:
  - Digit i>0 is blank when nibble i and every higher nibble of shadow equal 0.
  - Digit 0 is never blank.
  - Illegal codes count as nonzero.
- Blank slot outputs: an = all ones, seg = 0x7F. The slot time is still consumed.
- Non-blank slot outputs: an = ~(1<<dig_idx), seg = decode(shadow nibble dig_idx).
- seg, an and frame are registered. They are computed from the current dig_idx, div_cnt and shadow, and appear on the next edge.
- frame <= 1 when dig_idx==0 and div_cnt==0, else 0.

## Timing
- Reset asserted, taking effect immediately (async):
  - shadow=0, div_cnt=0, dig_idx=0.
  - seg=0x7F, an=all ones, frame=0.
- Reset release is sampled synchronously. First rising edge with reset=1:
  - an = ~1, seg = 0x40 (digit 0 shows 0).
  - frame = 1.
- Each digit slot lasts exactly REFRESH_DIV cycles. A frame lasts DIGITS*REFRESH_DIV cycles. frame period = DIGITS*REFRESH_DIV.
- Outputs lag dig_idx by one cycle. an never shows two low bits.
- Load latency: load sampled at edge N; the new value is reflected on seg at edge N+1 if that slot's digit is displayed.
- Load on the same edge as a dig_idx advance: both take effect. The next output uses the new index and the new shadow.
- Load held high for several cycles: shadow tracks bcd_in every cycle.
- Reset mid-frame: all state and outputs return to reset values at once. The scan restarts from digit 0 after release.

## Test plan
- **Reset.** Hold reset=0 for 12 ns, then release.
  - During reset: seg=0x7F, an=4'b1111, frame=0.
  - First edge after release: an=4'b1110, seg=0x40, frame=1.
- **Scan cadence** (DIGITS=4, REFRESH_DIV=4), load bcd_in=16'h1234:
  - Each slot lasts 4 cycles. Sequence is an=1110/seg=0x19, 1101/0x30, 1011/0x24, 0111/0x79.
  - frame pulses every 16 cycles.
- **Leading-zero blanking.** Load 16'h0070.
  - Digits 2 and 3 show an=1111, seg=0x7F.
  - Digit 1 shows 0x78. Digit 0 shows 0x40.
  - Repeat with BLANK_LZ=0: digits 3 and 2 show 0x40 with their anodes low.
- **Illegal code.** Load 16'h00A5.
  - Digit 1 shows seg=0x3F, digit 0 shows 0x12.
  - Digits 3 and 2 are blanked.
- **Load versus slot boundary.** Pulse load with 16'h9999 on the edge where dig_idx advances 0 -> 1.
  - The next output has an=1101, seg=0x10.
  - No glitch value appears, and cadence is unchanged.
- **Mid-frame reset.** Assert reset during digit 2 of a frame.
  - Outputs go to 0x7F/1111 immediately.
  - shadow is cleared: after release the display shows a single 0 on digit 0, and frame=1 on the first edge.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// Multiplexed common-anode seven-segment driver: captures BCD digits on load and
// scans them round-robin with optional leading-zero blanking and a dash for illegal codes.
module bcd_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [DW-1:0]          div_q, div_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   frame_q, frame_d;
  logic [DIGITS-1:0]      lz_blank;
  logic                   slot_end;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    slot_end = (div_q == DIV_LAST);
    div_d    = slot_end ? '0 : div_q + DW'(1);
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    shadow_d = load ? bcd_in : shadow_q;
  end

  // Digit i is a leading zero when it and every nibble above it are zero; digit 0 never blanks.
  always_comb begin
    logic hi_zero;
    hi_zero  = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      hi_zero     = hi_zero & (shadow_q[i] == 4'd0);
      lz_blank[i] = hi_zero;
    end
  end

  always_comb begin
    frame_d = (idx_q == '0) && (div_q == '0);
    if (BLANK_LZ && lz_blank[idx_q]) begin
      seg_d = 7'h7F;
      an_d  = '1;
    end else begin
      seg_d = decode(shadow_q[idx_q]);
      an_d  = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
